// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage unsigned float multiplier; optional rounding via FP_MUL_ROUND_EN
module fp_mul_pipe #(
    parameter int HALVE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [30:0] float_a,
    input  logic [30:0] float_b,
    input  logic [30:0] float_in_delay,
    output logic [30:0] float_out,
    output logic [30:0] float_out_delay,
    output logic        ready
);

    localparam logic [30:0] SAT_VALUE = 31'h7F7FFFFF;

    logic [2:0]         vld;

    logic [23:0]        sig_a1, sig_b1;
    logic signed [9:0]  exp1;
    logic               zero1, ovf1;
    logic [30:0]        dly1;

    logic [47:0]        prod2;
    logic signed [9:0]  exp2;
    logic               zero2, ovf2;
    logic [30:0]        dly2;

    logic [22:0]        man_t, man_f;
    logic [23:0]        man_r;
    logic               g, r, s, rnd_up;
    logic signed [9:0]  exp_n, exp_f;
    logic [30:0]        result;

    assign ready = vld[2];

    // Valid shift chain; one bit per pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld <= 3'b000;
        else     vld <= {vld[1:0], valid};
    end

    // S1: capture significands with hidden 1, classify operands, sum exponents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_a1 <= '0;
            sig_b1 <= '0;
            exp1   <= '0;
            zero1  <= 1'b0;
            ovf1   <= 1'b0;
            dly1   <= '0;
        end else if (valid) begin
            sig_a1 <= {1'b1, float_a[22:0]};
            sig_b1 <= {1'b1, float_b[22:0]};
            exp1   <= signed'({2'b00, float_a[30:23]} + {2'b00, float_b[30:23]}
                              - 10'd127 - 10'(HALVE));
            zero1  <= (float_a[30:23] == 8'd0) || (float_b[30:23] == 8'd0);
            ovf1   <= (float_a[30:23] == 8'hFF) || (float_b[30:23] == 8'hFF);
            dly1   <= float_in_delay;
        end
    end

    // S2: full 24x24 significand product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod2 <= '0;
            exp2  <= '0;
            zero2 <= 1'b0;
            ovf2  <= 1'b0;
            dly2  <= '0;
        end else if (vld[0]) begin
            prod2 <= 48'(sig_a1) * 48'(sig_b1);
            exp2  <= exp1;
            zero2 <= zero1;
            ovf2  <= ovf1;
            dly2  <= dly1;
        end
    end

    // S3 combinational: normalize, round, apply carry, then range-check.
    always_comb begin
        man_t  = '0;
        g      = 1'b0;
        r      = 1'b0;
        s      = 1'b0;
        exp_n  = exp2;
        if (prod2[47]) begin
            man_t = prod2[46:24];
            g     = prod2[23];
            r     = prod2[22];
            s     = |prod2[21:0];
            exp_n = exp2 + 10'sd1;
        end else begin
            man_t = prod2[45:23];
            g     = prod2[22];
            r     = prod2[21];
            s     = |prod2[20:0];
        end
`ifdef FP_MUL_ROUND_EN
        rnd_up = g & (r | s | man_t[0]);
`else
        // Truncation: the guard/round/sticky bits are simply dropped.
        rnd_up = (g | r | s) & 1'b0;
`endif
        man_r = {1'b0, man_t} + {23'd0, rnd_up};
        if (man_r[23]) begin
            man_f = '0;
            exp_f = exp_n + 10'sd1;
        end else begin
            man_f = man_r[22:0];
            exp_f = exp_n;
        end
        if (zero2)                  result = '0;
        else if (ovf2)              result = SAT_VALUE;
        else if (exp_f <= 10'sd0)   result = '0;
        else if (exp_f >= 10'sd255) result = SAT_VALUE;
        else                        result = {exp_f[7:0], man_f};
    end

    // S3 register: outputs hold their value between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            float_out       <= '0;
            float_out_delay <= '0;
        end else if (vld[1]) begin
            float_out       <= result;
            float_out_delay <= dly2;
        end
    end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter: HALVE, default 0, 1 = scale product by 0.5 (result exponent decremented by 1), which forms the 0.5*x*y*y term of the Newton step.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the sole clock.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: valid  input  1  operands present this cycle.
REQ-005 SHALL have ports: float_a, float_b  input  31 each  unsigned floats, laid out as {exp[30:23], man[22:0]}, bias 127, sign implied positive.
REQ-006 SHALL have port: float_in_delay  input  31  side value carried alongside the operands.
REQ-007 SHALL have port: float_out  output  31  product in the same format.
REQ-008 SHALL have port: float_out_delay  output  31  float_in_delay aligned with float_out.
REQ-009 SHALL have port: ready  output  1  float_out and float_out_delay valid this cycle.

Function
REQ-010 SHALL be a 3-stage pipeline. S1: register operands, test for zero, compute exponent sum ea+eb-127-HALVE (10-bit signed). S2: 24x24 significand multiply (hidden 1 restored) into a 48-bit register. S3: normalize, round, range-check, register the outputs.
REQ-011 SHALL assert ready exactly 3 clock edges after the edge that sampled valid=1; valid SHALL propagate through a 3-bit valid shift chain.
REQ-012 SHALL accept a new operand every cycle with no stalls or bubbles; there is no backpressure.
REQ-013 SHALL load each stage's data registers only when that stage's valid bit is set; outputs SHALL hold their last value while ready=0.
REQ-014 SHALL normalize products in [2,4) by shifting right one bit and adding 1 to the exponent; products in [1,2) are not shifted.
REQ-015 SHALL treat any operand with exp==0 as zero (denormals flushed), giving float_out=0.
REQ-016 SHALL treat an operand with exp==255 as overflow.
REQ-017 SHALL flush to 0 when the final exponent is <=0 (underflow).
REQ-018 SHALL saturate to 31'h7F7FFFFF when the final exponent is >=255 (overflow), including overflow caused by a rounding carry.
REQ-019 SHALL, on a rounding carry out of the mantissa, set mantissa=0 and add 1 to the exponent before the range check.
REQ-020 SHALL pass float_in_delay through 3 registers with the same enables as the data path, so it leaves with its own product.

Reset
REQ-021 SHALL, while rst=1, asynchronously clear the valid chain, all stage registers, float_out, float_out_delay and ready to 0.
REQ-022 SHALL discard operations in flight when rst asserts mid-stream; no ready pulse for them SHALL appear after rst deasserts.
REQ-023 SHALL sample valid on the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL, when macro FP_MUL_ROUND_EN is defined, round to nearest, ties to even, using the guard bit, round bit and OR-sticky of the discarded product bits.
REQ-025 SHALL, when FP_MUL_ROUND_EN is undefined, truncate the discarded bits; latency and all other behaviour SHALL be unchanged.

Verification
REQ-026 SHALL cover: HALVE=0, a=31'h3F800000, b=31'h3F800000 -> float_out=31'h3F800000, ready 3 cycles after valid.
REQ-027 SHALL cover: HALVE=0, a=31'h40000000 (2.0), b=31'h40400000 (3.0), 3 back-to-back repeats, float_in_delay=1,2,3 -> float_out=31'h40C00000 on 3 consecutive cycles, float_out_delay=1,2,3.
REQ-028 SHALL cover: HALVE=1, a=b=31'h3FC00000 (1.5) -> float_out=31'h3F900000 (1.125).
REQ-029 SHALL cover: a=31'h3FC00000, b=31'h3F800001 -> float_out=31'h3FC00002 with FP_MUL_ROUND_EN (tie rounds to even) and 31'h3FC00001 without it.
REQ-030 SHALL cover: a=31'h7F000000, b=31'h7F000000 -> 31'h7F7FFFFF; a=0, b=31'h3F800000 -> 0; a=b=31'h00800000 -> 0 (underflow).
REQ-031 SHALL cover: rst pulsed one cycle after valid -> ready stays 0 and all outputs stay 0 until new valid input.
